// File: rtl/enemy_fleet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enemy_fleet_pkg
// Description : Shared types and helpers for the enemy fleet.
//               - slot_state_t : per-slot life cycle (IDLE, FLY, BOOM)
//               - LFSR_SEED    : reset value of the spawn LFSR
//               - LFSR_TAPS    : feedback mask of the spawn LFSR
//               - lfsr_next()  : one step of the 16-bit Fibonacci LFSR
// Revision    : 1.0 - initial release
// ============================================================================
package enemy_fleet_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FLY  = 2'd1,
      BOOM = 2'd2
   } slot_state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Taps 16,14,13,11 of the right-shifting Fibonacci form sit at register
   // bits 0,2,3,5; the XOR of those bits becomes the new bit 15.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {^(cur & LFSR_TAPS), cur[15:1]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_slot.sv
`default_nettype none
// ============================================================================
// Module      : enemy_slot
// Description : One enemy slot: life-cycle FSM, position and boom timer.
//               Optional macro ENEMY_DRIFT_EN adds horizontal drift.
// Ports       : clk, rst          clock / async active-high reset
//               i_move_tick       advances motion and boom timer
//               i_hit             kill request (only honoured in FLY)
//               i_revive          force IDLE, positions hold
//               i_spawn           spawn grant (only honoured in IDLE)
//               i_seed            LFSR byte used for the spawn x position
//               i_seed_dir        initial drift direction (ENEMY_DRIFT_EN)
//               o_pos_x, o_pos_y  current sprite origin
//               o_alive           slot is in FLY
//               o_booming         slot is in BOOM
//               o_escape          one-clk pulse on escape
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_slot
   import enemy_fleet_pkg::*;
#(
   parameter int COORD_W    = 10,
   parameter int X_MAX      = 190,
   parameter int Y_LIMIT    = 430,
   parameter int BOOM_TICKS = 32
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_move_tick,
   input  logic               i_hit,
   input  logic               i_revive,
   input  logic               i_spawn,
   input  logic [7:0]         i_seed,
`ifdef ENEMY_DRIFT_EN
   input  logic               i_seed_dir,
`endif
   output logic [COORD_W-1:0] o_pos_x,
   output logic [COORD_W-1:0] o_pos_y,
   output logic               o_alive,
   output logic               o_booming,
   output logic               o_escape
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_FLY  = FLY;
   localparam logic [1:0] ST_BOOM = BOOM;

   localparam int                 CNT_W        = $clog2(BOOM_TICKS + 1);
   localparam logic [CNT_W-1:0]   C_BOOM_LOAD  = CNT_W'(BOOM_TICKS);
   localparam logic [CNT_W-1:0]   C_BOOM_LAST  = CNT_W'(1);
   localparam logic [COORD_W-1:0] C_Y_LIMIT    = COORD_W'(Y_LIMIT);
   localparam logic [COORD_W-1:0] C_X_SPAN     = COORD_W'(X_MAX + 1);
`ifdef ENEMY_DRIFT_EN
   localparam logic [COORD_W-1:0] C_X_MAX      = COORD_W'(X_MAX);
`endif

   logic [1:0]         r_state;
   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_escape;
`ifdef ENEMY_DRIFT_EN
   logic               r_dir;
`endif

   // Scale the 8-bit seed onto 0..X_MAX: seed*(X_MAX+1)/256 never reaches
   // X_MAX+1, so every spawn lands inside the playfield.
   logic [COORD_W+7:0] w_prod;
   logic [COORD_W-1:0] w_spawn_x;

   assign w_prod    = {{COORD_W{1'b0}}, i_seed} * {8'd0, C_X_SPAN};
   assign w_spawn_x = COORD_W'(w_prod >> 8);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_x      <= '0;
         r_y      <= '0;
         r_cnt    <= '0;
         r_escape <= 1'b0;
`ifdef ENEMY_DRIFT_EN
         r_dir    <= 1'b0;
`endif
      end else begin
         r_escape <= 1'b0;
         if (i_revive) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (i_spawn) begin
                     r_state <= ST_FLY;
                     r_x     <= w_spawn_x;
                     r_y     <= '0;
`ifdef ENEMY_DRIFT_EN
                     r_dir   <= i_seed_dir;
`endif
                  end
               end
               ST_FLY: begin
                  // A hit outranks an escape on the same tick.
                  if (i_hit) begin
                     r_state <= ST_BOOM;
                     r_cnt   <= C_BOOM_LOAD;
                  end else if (i_move_tick) begin
                     if (r_y >= C_Y_LIMIT) begin
                        r_state  <= ST_IDLE;
                        r_escape <= 1'b1;
                     end else begin
                        r_y <= r_y + 1'b1;
`ifdef ENEMY_DRIFT_EN
                        // At a wall the direction flips and x holds
                        // for this tick.
                        if (r_dir) begin
                           if (r_x == C_X_MAX) r_dir <= 1'b0;
                           else                r_x   <= r_x + 1'b1;
                        end else begin
                           if (r_x == '0)      r_dir <= 1'b1;
                           else                r_x   <= r_x - 1'b1;
                        end
`endif
                     end
                  end
               end
               ST_BOOM: begin
                  if (i_move_tick) begin
                     if (r_cnt == C_BOOM_LAST) r_state <= ST_IDLE;
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_pos_x   = r_x;
   assign o_pos_y   = r_y;
   assign o_alive   = (r_state == ST_FLY);
   assign o_booming = (r_state == ST_BOOM);
   assign o_escape  = r_escape;

endmodule
`default_nettype wire

// File: rtl/enemy_fleet.sv
`default_nettype none
// ============================================================================
// Module      : enemy_fleet
// Description : N_ENEMY enemy slots with spawn LFSR, spawn arbiter, escape
//               merge and per-pixel hit test producing a sprite address.
//               Optional macro ENEMY_DRIFT_EN enables horizontal drift.
// Ports       : clk, rst          clock / async active-high reset
//               move_tick         advances motion and timers
//               hit[N_ENEMY]      per-slot kill request
//               revive            clear all slots
//               x, y              current scan pixel
//               enemy_x/enemy_y   packed slot positions
//               alive/booming     per-slot FLY / BOOM flags
//               escape            one-clk pulse when any slot escapes
//               pix_valid/slot/boom/addr  registered scan-pixel result
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_fleet
   import enemy_fleet_pkg::*;
#(
   parameter int N_ENEMY    = 4,
   parameter int COORD_W    = 10,
   parameter int SPR_W      = 50,
   parameter int SPR_H      = 50,
   parameter int X_MAX      = 190,
   parameter int Y_LIMIT    = 430,
   parameter int BOOM_TICKS = 32,
   parameter int SPAWN_GAP  = 64
)
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       move_tick,
   input  logic [N_ENEMY-1:0]         hit,
   input  logic                       revive,
   input  logic [COORD_W-1:0]         x,
   input  logic [COORD_W-1:0]         y,
   output logic [N_ENEMY*COORD_W-1:0] enemy_x,
   output logic [N_ENEMY*COORD_W-1:0] enemy_y,
   output logic [N_ENEMY-1:0]         alive,
   output logic [N_ENEMY-1:0]         booming,
   output logic                       escape,
   output logic                       pix_valid,
   output logic [2:0]                 pix_slot,
   output logic                       pix_boom,
   output logic [11:0]                pix_addr
);

   localparam int                 SCNT_W     = $clog2(SPAWN_GAP + 1);
   localparam logic [SCNT_W-1:0]  C_GAP_LAST = SCNT_W'(SPAWN_GAP - 1);
   localparam logic [COORD_W-1:0] C_SPR_W    = COORD_W'(SPR_W);
   localparam logic [COORD_W-1:0] C_SPR_H    = COORD_W'(SPR_H);
   localparam logic [11:0]        C_ROW_STEP = 12'(SPR_W);

   logic [15:0]        r_lfsr;
   logic [SCNT_W-1:0]  r_spawn_cnt;

   logic               w_spawn_due;
   logic [N_ENEMY-1:0] w_idle;
   logic [N_ENEMY-1:0] w_grant;
   logic               w_found;
   logic [N_ENEMY-1:0] w_escape;
   logic [N_ENEMY-1:0] w_cover;

   logic [COORD_W-1:0] w_sx [N_ENEMY];
   logic [COORD_W-1:0] w_sy [N_ENEMY];
   logic [COORD_W-1:0] w_dx [N_ENEMY];
   logic [COORD_W-1:0] w_dy [N_ENEMY];

   // LFSR free-runs; revive deliberately leaves it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_lfsr <= LFSR_SEED;
      else     r_lfsr <= lfsr_next(r_lfsr);
   end

   assign w_spawn_due = move_tick & (r_spawn_cnt == C_GAP_LAST) & ~revive;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_spawn_cnt <= '0;
      end else if (revive) begin
         r_spawn_cnt <= '0;
      end else if (move_tick) begin
         if (r_spawn_cnt == C_GAP_LAST) r_spawn_cnt <= '0;
         else                           r_spawn_cnt <= r_spawn_cnt + 1'b1;
      end
   end

   // Lowest-index idle slot gets the grant; with no idle slot the attempt
   // simply evaporates.
   always_comb begin
      w_grant = '0;
      w_found = 1'b0;
      for (int i = 0; i < N_ENEMY; i++) begin
         if (!w_found && w_idle[i]) begin
            w_grant[i] = w_spawn_due;
            w_found    = 1'b1;
         end
      end
   end

   generate
      for (genvar i = 0; i < N_ENEMY; i++) begin : g_slot
         enemy_slot #(
            .COORD_W    (COORD_W),
            .X_MAX      (X_MAX),
            .Y_LIMIT    (Y_LIMIT),
            .BOOM_TICKS (BOOM_TICKS)
         ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_move_tick (move_tick),
            .i_hit       (hit[i]),
            .i_revive    (revive),
            .i_spawn     (w_grant[i]),
            .i_seed      (r_lfsr[7:0]),
`ifdef ENEMY_DRIFT_EN
            .i_seed_dir  (r_lfsr[8]),
`endif
            .o_pos_x     (w_sx[i]),
            .o_pos_y     (w_sy[i]),
            .o_alive     (alive[i]),
            .o_booming   (booming[i]),
            .o_escape    (w_escape[i])
         );

         assign enemy_x[i*COORD_W +: COORD_W] = w_sx[i];
         assign enemy_y[i*COORD_W +: COORD_W] = w_sy[i];
         assign w_idle[i] = ~alive[i] & ~booming[i];

         // Unsigned wrap makes pixels left of / above the box look huge,
         // so a single compare per axis rejects both sides.
         assign w_dx[i]    = x - w_sx[i];
         assign w_dy[i]    = y - w_sy[i];
         assign w_cover[i] = ~w_idle[i] & (w_dx[i] < C_SPR_W) & (w_dy[i] < C_SPR_H);
      end
   endgenerate

   assign escape = |w_escape;

   logic        w_pv;
   logic [2:0]  w_ps;
   logic        w_pb;
   logic [11:0] w_pa;

   // Walk from the top index down so the lowest covering slot is the last
   // writer and therefore wins.
   always_comb begin
      w_pv = 1'b0;
      w_ps = '0;
      w_pb = 1'b0;
      w_pa = '0;
      for (int i = N_ENEMY - 1; i >= 0; i--) begin
         if (w_cover[i]) begin
            w_pv = 1'b1;
            w_ps = 3'(i);
            w_pb = booming[i];
            w_pa = 12'(w_dx[i]) + 12'(w_dy[i]) * C_ROW_STEP;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_valid <= 1'b0;
         pix_slot  <= '0;
         pix_boom  <= 1'b0;
         pix_addr  <= '0;
      end else begin
         pix_valid <= w_pv;
         pix_slot  <= w_ps;
         pix_boom  <= w_pb;
         pix_addr  <= w_pa;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_enemy_fleet.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_fleet
// Description : Directed self-checking bench for enemy_fleet (default build,
//               ENEMY_DRIFT_EN undefined) with SPAWN_GAP=4, BOOM_TICKS=32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_fleet;

   localparam int N  = 4;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          move_tick;
   logic [N-1:0]  hit;
   logic          revive;
   logic [CW-1:0] x, y;
   logic [N*CW-1:0] enemy_x, enemy_y;
   logic [N-1:0]  alive, booming;
   logic          escape, pix_valid, pix_boom;
   logic [2:0]    pix_slot;
   logic [11:0]   pix_addr;

   always #5 clk = ~clk;

   enemy_fleet #(
      .N_ENEMY(4), .COORD_W(10), .SPR_W(50), .SPR_H(50), .X_MAX(190),
      .Y_LIMIT(430), .BOOM_TICKS(32), .SPAWN_GAP(4)
   ) dut (
      .clk(clk), .rst(rst), .move_tick(move_tick), .hit(hit), .revive(revive),
      .x(x), .y(y), .enemy_x(enemy_x), .enemy_y(enemy_y), .alive(alive),
      .booming(booming), .escape(escape), .pix_valid(pix_valid),
      .pix_slot(pix_slot), .pix_boom(pix_boom), .pix_addr(pix_addr)
   );

   int total = 0;
   int bad   = 0;

   // Independent LFSR model: right-shifting Fibonacci, taps 16,14,13,11.
   logic [15:0] m_lfsr;
   always @(posedge clk) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
   end

   logic [CW-1:0] tick_x;
   logic [CW-1:0] ex_m [N];
   logic [CW-1:0] ey_m [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] sx(input int i);
      return enemy_x[i*CW +: CW];
   endfunction

   function automatic logic [CW-1:0] sy(input int i);
      return enemy_y[i*CW +: CW];
   endfunction

   // One move_tick pulse; tick_x is the spawn x a grant on this edge loads.
   task automatic tick();
      @(negedge clk);
      tick_x    = CW'((32'(m_lfsr[7:0]) * 191) >> 8);
      move_tick = 1'b1;
      @(negedge clk);
      move_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic tick_hit(input logic [N-1:0] m);
      @(negedge clk);
      move_tick = 1'b1;
      hit       = m;
      @(negedge clk);
      move_tick = 1'b0;
      hit       = '0;
   endtask

   task automatic pulse_hit(input logic [N-1:0] m);
      @(negedge clk);
      hit = m;
      @(negedge clk);
      hit = '0;
   endtask

   // Scan one pixel (all slots FLY) and compare with a lowest-index-wins model.
   task automatic scan(input string tag, input logic [CW-1:0] px, input logic [CW-1:0] py);
      logic        v;
      logic [2:0]  s;
      logic [11:0] a;
      logic [CW-1:0] dx, dy;
      v = 1'b0; s = '0; a = '0;
      for (int i = N - 1; i >= 0; i--) begin
         dx = px - ex_m[i];
         dy = py - ey_m[i];
         if (dx < 50 && dy < 50) begin
            v = 1'b1;
            s = 3'(i);
            a = 12'(dx) + 12'(dy) * 12'd50;
         end
      end
      @(negedge clk);
      x = px;
      y = py;
      @(negedge clk);
      chk({tag, "_valid"}, pix_valid, v);
      chk({tag, "_slot"},  pix_slot,  s);
      chk({tag, "_addr"},  pix_addr,  a);
   endtask

   initial begin
      rst = 1'b1; move_tick = 1'b0; hit = '0; revive = 1'b0; x = '0; y = '0;
      repeat (3) @(negedge clk);
      chk("rst_alive",   alive,     0);
      chk("rst_booming", booming,   0);
      chk("rst_escape",  escape,    0);
      chk("rst_pvalid",  pix_valid, 0);
      chk("rst_paddr",   pix_addr,  0);
      chk("rst_ex",      enemy_x,   0);
      chk("rst_ey",      enemy_y,   0);
      rst = 1'b0;

      // First spawn on the 4th tick, into slot 0.
      ticks(3);
      chk("pre_spawn_alive", alive, 0);
      tick();
      ex_m[0] = tick_x;
      chk("spawn0_alive", alive, 4'b0001);
      chk("spawn0_y",     sy(0), 0);
      chk("spawn0_x",     sx(0), ex_m[0]);
      chk("spawn0_range", sx(0) <= 190, 1);

      ticks(3);
      tick();
      ex_m[1] = tick_x;
      chk("spawn1_alive", alive, 4'b0011);
      chk("spawn1_y0",    sy(0), 4);
      chk("spawn1_y1",    sy(1), 0);
      chk("spawn1_x",     sx(1), ex_m[1]);

      // Kill slot 0, then hits on a BOOM slot and on an IDLE slot are ignored.
      pulse_hit(4'b0001);
      chk("hit_booming", booming, 4'b0001);
      chk("hit_alive",   alive,   4'b0010);
      pulse_hit(4'b1001);
      chk("hit_ign_alive",   alive,   4'b0010);
      chk("hit_ign_booming", booming, 4'b0001);

      x = ex_m[0] + 10'd1; y = 10'd5;
      @(negedge clk);
      chk("boom_pvalid", pix_valid, 1);
      chk("boom_pslot",  pix_slot,  0);
      chk("boom_pboom",  pix_boom,  1);
      chk("boom_paddr",  pix_addr,  51);

      ticks(3); tick(); ex_m[2] = tick_x;
      ticks(3); tick(); ex_m[3] = tick_x;
      ticks(23);
      chk("boom31_booming", booming, 4'b0001);
      chk("boom31_alive",   alive,   4'b1110);
      chk("boom31_y",       sy(0),   4);
      chk("boom31_x",       sx(0),   ex_m[0]);
      chk("spawn2_x",       sx(2),   ex_m[2]);
      chk("spawn3_x",       sx(3),   ex_m[3]);
      // 32nd tick ends the boom; the spawn attempt on the same tick is dropped.
      tick();
      chk("boom32_booming", booming, 4'b0000);
      chk("boom32_alive",   alive,   4'b1110);

      ticks(3);
      tick();
      ex_m[0] = tick_x;
      chk("respawn0_alive", alive, 4'b1111);
      chk("respawn0_y",     sy(0), 0);
      chk("respawn0_x",     sx(0), ex_m[0]);
      chk("y1_36",          sy(1), 36);
      chk("y3_28",          sy(3), 28);

      ey_m[0] = 10'd0; ey_m[1] = 10'd36; ey_m[2] = 10'd32; ey_m[3] = 10'd28;
      scan("pix_in0",  ex_m[0] + 10'd3, 10'd2);
      chk("pix_in0_addr103", pix_addr, 103);
      scan("pix_left0", ex_m[0] - 10'd1, 10'd2);
      chk("pix_left0_off", pix_valid, 0);
      for (int i = 1; i < N; i++) begin
         scan("pix_mid",    ex_m[i] + 10'd10, ey_m[i] + 10'd20);
         scan("pix_corner", ex_m[i] + 10'd49, ey_m[i] + 10'd49);
         scan("pix_right",  ex_m[i] + 10'd50, ey_m[i]);
      end

      // Slot 1 reaches y=430, then escapes on the next tick.
      ticks(394);
      chk("esc_pre_y",     sy(1), 430);
      chk("esc_pre_alive", alive, 4'b1111);
      tick();
      chk("esc_pulse", escape, 1);
      chk("esc_alive", alive,  4'b1101);
      @(negedge clk);
      chk("esc_one_clk", escape, 0);

      tick();
      ex_m[1] = tick_x;
      chk("refill1_alive", alive, 4'b1111);
      chk("refill1_x",     sx(1), ex_m[1]);
      ticks(2);
      chk("y2_430", sy(2), 430);
      tick_hit(4'b0100);
      chk("hitesc_booming", booming, 4'b0100);
      chk("hitesc_escape",  escape,  0);
      chk("hitesc_alive",   alive,   4'b1011);
      @(negedge clk);
      chk("hitesc_escape2", escape, 0);

      // Revive while slot 2 booms and a spawn is due on the same tick.
      @(negedge clk);
      move_tick = 1'b1; revive = 1'b1;
      @(negedge clk);
      move_tick = 1'b0; revive = 1'b0;
      chk("rev_alive",   alive,   0);
      chk("rev_booming", booming, 0);
      chk("rev_escape",  escape,  0);
      chk("rev_hold_y2", sy(2),   430);
      chk("rev_hold_y3", sy(3),   427);
      chk("rev_hold_y1", sy(1),   3);

      ticks(3);
      chk("rev_cnt_alive", alive, 0);
      tick();
      ex_m[0] = tick_x;
      chk("rev_spawn_alive", alive, 4'b0001);
      chk("rev_spawn_x",     sx(0), ex_m[0]);

      // Revive mid-gap must restart the spawn counter.
      tick();
      @(negedge clk); revive = 1'b1;
      @(negedge clk); revive = 1'b0;
      chk("rev2_alive", alive, 0);
      ticks(3);
      chk("rev2_cnt_alive", alive, 0);
      tick();
      chk("rev2_spawn_alive", alive, 4'b0001);
      chk("rev2_spawn_y",     sy(0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/enemy_fleet.md
Name: enemy_fleet

Overview:
Parametrised successor to the single-enemy judge. Manages N_ENEMY independent enemy slots in one clock domain. Each slot spawns at an LFSR-derived x position, descends, escapes or explodes, then returns to idle. Performs the per-pixel hit test for the VGA scan and emits a sprite-ROM address. Sits between the game controller (hit/revive/score) and the pixel mixer, which owns the sprite ROMs and transparency.

Parameters:
N_ENEMY, 4, number of enemy slots (1..8)
COORD_W, 10, coordinate width in bits
SPR_W, 50, sprite width in px
SPR_H, 50, sprite height in px
X_MAX, 190, largest legal spawn x (playfield width minus SPR_W)
Y_LIMIT, 430, y at which a flying enemy escapes
BOOM_TICKS, 32, explosion duration in move ticks (>=1)
SPAWN_GAP, 64, move ticks between spawn attempts (>=1)

Ports:
clk  in  1  system/pixel clock
rst  in  1  asynchronous, active-high reset
move_tick  in  1  one-clk pulse; advances motion and timers
hit  in  N_ENEMY  one-clk kill request per slot
revive  in  1  one-clk pulse; clear all slots
x  in  COORD_W  current scan pixel column
y  in  COORD_W  current scan pixel row
enemy_x  out  N_ENEMY*COORD_W  slot i at bits [i*COORD_W +: COORD_W]
enemy_y  out  N_ENEMY*COORD_W  packed like enemy_x
alive  out  N_ENEMY  slot in FLY
booming  out  N_ENEMY  slot in BOOM
escape  out  1  one-clk pulse when any slot escapes
pix_valid  out  1  scan pixel inside a FLY or BOOM slot box
pix_slot  out  3  index of the covering slot
pix_boom  out  1  covering slot is in BOOM (select explosion ROM)
pix_addr  out  12  col + row*SPR_W within the sprite

Behaviour:
- Reset (async): all slots IDLE; x=y=0; alive=booming=0; escape=0; pix_* = 0; spawn counter=0; LFSR=16'hACE1.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk, never reset by revive.
- Per-slot FSM (all transitions on clk edge):
  - IDLE->FLY on spawn grant. Load x = (lfsr[7:0]*(X_MAX+1))>>8 (always 0..X_MAX), y=0.
  - FLY->BOOM when hit[i]=1. Boom counter loads BOOM_TICKS; x/y freeze.
  - FLY, move_tick, y>=Y_LIMIT: ->IDLE and escape pulses. Otherwise y<=y+1 on move_tick.
  - BOOM, move_tick: counter decrements; at counter==1 ->IDLE.
  - hit on an IDLE or BOOM slot: ignored.
  - hit and escape in the same cycle: BOOM wins, no escape pulse.
- Spawn:
  - Counter increments on move_tick.
  - On move_tick with counter==SPAWN_GAP-1: counter wraps to 0; the lowest-index IDLE slot is granted.
  - No IDLE slot: the attempt is dropped (no queueing).
- revive:
  - Highest priority: all slots IDLE, spawn counter 0, escape suppressed that cycle.
  - x/y hold their last values.
- Pixel path, registered with 1 clk latency from x/y:
  - Slot i covers when x-ex_i < SPR_W and y-ey_i < SPR_H (unsigned subtract, so underflow rejects) and the slot is not IDLE.
  - Lowest covering index wins.
  - pix_addr is computed with SPR_W as a constant multiply; pix_* = 0 when nothing covers.
- Multiple escapes in one cycle produce a single escape pulse.

Optional Feature:
ENEMY_DRIFT_EN:
- Defined: each slot latches dir=lfsr[8] at spawn. In FLY on move_tick, x moves +1 (dir=1) or -1 (dir=0). At x==X_MAX going +, or x==0 going -, dir flips and x holds that tick.
- Undefined: x constant after spawn and no dir register exists.

Decomposition:
- Package enemy_fleet_pkg: slot state enum (IDLE, FLY, BOOM), LFSR seed/taps constants, lfsr_next function.
- One sub-module, enemy_slot: single-slot FSM, position and boom counter. Instantiated N_ENEMY times by a generate loop.
- Top level holds the LFSR, spawn arbiter, escape OR and pixel priority mux.

Test Plan:
- Reset, then SPAWN_GAP=4, 4 move_ticks -> slot0 alive, y=0, x within 0..190. Second spawn goes to slot1 after 4 more ticks.
- Slot0 flying, hit[0] pulse -> booming[0]=1 next clk, x/y frozen. After 32 move_ticks -> alive[0]=booming[0]=0.
- Slot at y=430, move_tick -> escape high for exactly 1 clk, slot IDLE. Repeat with hit[i] asserted the same cycle -> BOOM, no escape.
- All 4 slots busy at a spawn attempt -> no change. The next attempt after a slot frees spawns into the lowest idle index.
- Slots 0 and 2 overlapping, scan x=ex0+3, y=ey0+2 -> 1 clk later pix_valid=1, pix_slot=0, pix_addr=103. Scan at x=ex0-1 -> pix_valid=0.
- revive during BOOM with a spawn due the same cycle -> all IDLE, spawn counter 0, no escape pulse. With ENEMY_DRIFT_EN and x=190, dir=1: tick -> x holds, next tick x=189.
